// File: rtl/minterm_pkg.sv
// Shared constants and types for the three-input sum-of-minterms function block.
package minterm_pkg;

    localparam int N_INPUTS = 3;

    typedef logic [7:0] minterm_vec_t;

    // Odd parity of {A,B,C}: minterms 1, 2, 4 and 7.
    localparam minterm_vec_t DEFAULT_MINTERMS = 8'b1001_0110;

endpackage : minterm_pkg

// File: rtl/minterm_decoder.sv
// 3-to-8 one-hot minterm decoder; purely combinational, zero latency, no backpressure.
// Each line is the AND of three literals, so an unknown input propagates as X.
module minterm_decoder
    import minterm_pkg::*;
(
    input  logic [N_INPUTS-1:0] idx_i,
    output minterm_vec_t        m_o
);

    for (genvar g = 0; g < 8; g++) begin : g_line
        localparam logic [N_INPUTS-1:0] K = g[N_INPUTS-1:0];
        // XNOR with a constant picks the true or complemented literal per input.
        assign m_o[g] = &(idx_i ~^ K);
    end

endmodule : minterm_decoder

// File: rtl/minterm_df.sv
// F = OR of masked minterms of {A,B,C}, plus one-cycle registered copies of F and m.
// Combinational outputs have zero latency; registered outputs lag one clk; no handshake.
module minterm_df
    import minterm_pkg::*;
#(
    parameter minterm_vec_t MINTERMS = DEFAULT_MINTERMS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         A,
    input  logic         B,
    input  logic         C,
    output logic         F,
    output logic [7:0]   m,
    output logic         F_q,
    output logic [7:0]   m_q
);

    minterm_vec_t m_dec;
    logic         f_d;
    minterm_vec_t m_d;

    minterm_decoder u_dec (
        .idx_i ({A, B, C}),
        .m_o   (m_dec)
    );

    // Only the OR stage depends on the mask; the decode never changes.
    assign m = m_dec;
    assign F = |(MINTERMS & m_dec);

    always_comb begin
        f_d = F;
        m_d = m_dec;
        if (rst) begin
            f_d = 1'b0;
            m_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        F_q <= f_d;
        m_q <= m_d;
    end

endmodule : minterm_df

// File: tb/tb_minterm_df.sv
// Directed bench for minterm_df: default mask, AND mask, all-zero and all-one masks.
module tb_minterm_df;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       A = 1'b0, B = 1'b0, C = 1'b0;

    logic       f_def, f_and, f_zero, f_one;
    logic [7:0] m_def, m_and, m_zero, m_one;
    logic       fq_def, fq_and, fq_zero, fq_one;
    logic [7:0] mq_def, mq_and, mq_zero, mq_one;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    minterm_df u_def (
        .clk(clk), .rst(rst), .A(A), .B(B), .C(C),
        .F(f_def), .m(m_def), .F_q(fq_def), .m_q(mq_def)
    );

    minterm_df #(.MINTERMS(8'b1000_0000)) u_and (
        .clk(clk), .rst(rst), .A(A), .B(B), .C(C),
        .F(f_and), .m(m_and), .F_q(fq_and), .m_q(mq_and)
    );

    minterm_df #(.MINTERMS(8'h00)) u_zero (
        .clk(clk), .rst(rst), .A(A), .B(B), .C(C),
        .F(f_zero), .m(m_zero), .F_q(fq_zero), .m_q(mq_zero)
    );

    minterm_df #(.MINTERMS(8'hFF)) u_one (
        .clk(clk), .rst(rst), .A(A), .B(B), .C(C),
        .F(f_one), .m(m_one), .F_q(fq_one), .m_q(mq_one)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] abc);
        {A, B, C} = abc;
    endtask

    // Hand-derived truth tables, index = {A,B,C}.
    logic [0:7] exp_f_def = 8'b0110_1001;
    logic [0:7] exp_f_and = 8'b0000_0001;
    logic [7:0] exp_m [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    initial begin
        // Combinational sweep, no reset ever applied.
        for (int i = 0; i < 8; i++) begin
            drive(i[2:0]);
            #10;
            chk($sformatf("F_def[%0d]", i),  {7'b0, f_def},  {7'b0, exp_f_def[i]});
            chk($sformatf("m_def[%0d]", i),  m_def,          exp_m[i]);
            chk($sformatf("F_and[%0d]", i),  {7'b0, f_and},  {7'b0, exp_f_and[i]});
            chk($sformatf("F_zero[%0d]", i), {7'b0, f_zero}, 8'h00);
            chk($sformatf("F_one[%0d]", i),  {7'b0, f_one},  8'h01);
            chk($sformatf("m_zero[%0d]", i), m_zero,         exp_m[i]);
            chk($sformatf("m_one[%0d]", i),  m_one,          exp_m[i]);
        end

        // Reset for two edges, then capture 111.
        @(negedge clk);
        rst = 1'b1;
        drive(3'b010);
        @(negedge clk);
        @(negedge clk);
        chk("rst F_q", {7'b0, fq_def}, 8'h00);
        chk("rst m_q", mq_def, 8'h00);
        chk("rst F_q one", {7'b0, fq_one}, 8'h00);
        chk("F during rst", {7'b0, f_def}, 8'h01);
        rst = 1'b0;
        drive(3'b111);
        @(negedge clk);
        chk("F_q 111", {7'b0, fq_def}, 8'h01);
        chk("m_q 111", mq_def, 8'h80);
        chk("F_q_and 111", {7'b0, fq_and}, 8'h01);

        // Reset in mid-stream overrides sampling for one edge.
        drive(3'b001);
        @(negedge clk);
        chk("F_q 001", {7'b0, fq_def}, 8'h01);
        chk("m_q 001", mq_def, 8'h02);
        rst = 1'b1;
        @(negedge clk);
        chk("mid rst F_q", {7'b0, fq_def}, 8'h00);
        chk("mid rst m_q", mq_def, 8'h00);
        chk("mid rst F", {7'b0, f_def}, 8'h01);
        rst = 1'b0;
        @(negedge clk);
        chk("post rst F_q", {7'b0, fq_def}, 8'h01);
        chk("post rst m_q", mq_def, 8'h02);

        // Back-to-back changes every edge: F_q lags F by one edge.
        drive(3'b011);
        #1;
        chk("b2b F 011", {7'b0, f_def}, 8'h00);
        @(negedge clk);
        chk("b2b F_q 011", {7'b0, fq_def}, 8'h00);
        drive(3'b100);
        #1;
        chk("b2b F 100", {7'b0, f_def}, 8'h01);
        chk("b2b F_q lag", {7'b0, fq_def}, 8'h00);
        @(negedge clk);
        chk("b2b F_q 100", {7'b0, fq_def}, 8'h01);
        drive(3'b110);
        @(negedge clk);
        chk("b2b F_q 110", {7'b0, fq_def}, 8'h00);
        chk("b2b m_q 110", mq_def, 8'h40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_minterm_df
